// File: rtl/xor_parity_frame_accum_if.sv
// Word-in / frame-result-out handshake bundle for xor_parity_frame_accum.
// slave modport is the accumulator side, master is the word source / result sink side.
interface xor_parity_frame_accum_if #(
    parameter int WIDTH     = 4,
    parameter int FRAME_LEN = 8
);
    localparam int CW = $clog2(FRAME_LEN + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_exp_parity;
    logic             out_valid;
    logic             out_ready;
    logic             out_parity;
    logic [CW-1:0]    out_count;
    logic             out_err;

    modport slave (
        input  in_valid, in_data, in_last, in_exp_parity, out_ready,
        output in_ready, out_valid, out_parity, out_count, out_err
    );

    modport master (
        output in_valid, in_data, in_last, in_exp_parity, out_ready,
        input  in_ready, out_valid, out_parity, out_count, out_err
    );
endinterface

// File: rtl/xor_parity_frame_accum.sv
// xor_parity_frame_accum: XOR-reduces each input word and accumulates the running
// parity over a frame closed by in_last or after FRAME_LEN words. The frame parity
// (ODD applied) and word count are returned on a valid/ready result channel.
// Optional macro PARITY_CHECK_EN: compares the frame parity against in_exp_parity
// sampled with the last word and reports the mismatch on out_err; without it
// out_err is tied to 0 and in_exp_parity is ignored.
module xor_parity_frame_accum #(
    parameter int WIDTH     = 4,
    parameter int FRAME_LEN = 8,
    parameter int ODD       = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    xor_parity_frame_accum_if.slave     bus
);
    localparam int CW = $clog2(FRAME_LEN + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_LEN);
    localparam logic          ODD_B   = (ODD != 0);

    logic [1:0]    state;
    logic          acc;
    logic [CW-1:0] cnt;
    logic          rdy_en;
    logic          par_q;
    logic [CW-1:0] count_q;
    logic          err_q;

    logic          wp;
    logic          acc_next;
    logic [CW-1:0] cnt_next;
    logic          accept;
    logic          frame_end;
    logic          in_ready_c;

    // in_ready stays low through reset and rises on the first clock after release
    assign in_ready_c = rdy_en && (state != S_HOLD);

    // Word parity, next accumulator values and end-of-frame detection
    always_comb begin
        wp        = ^bus.in_data;
        acc_next  = acc ^ wp;
        cnt_next  = cnt + CNT_ONE;
        accept    = bus.in_valid && in_ready_c;
        frame_end = bus.in_last || (cnt_next == CNT_MAX);
    end

    // Frame FSM, accumulator and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            acc     <= 1'b0;
            cnt     <= '0;
            rdy_en  <= 1'b0;
            par_q   <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                S_IDLE, S_ACCUM: begin
                    if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt_next;
                        if (frame_end) begin
                            state   <= S_HOLD;
                            par_q   <= acc_next ^ ODD_B;
                            count_q <= cnt_next;
`ifdef PARITY_CHECK_EN
                            err_q   <= (acc_next ^ ODD_B) != bus.in_exp_parity;
`else
                            err_q   <= 1'b0;
`endif
                        end else begin
                            state <= S_ACCUM;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                        acc   <= 1'b0;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    acc   <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifndef PARITY_CHECK_EN
    logic unused_exp_parity;
    assign unused_exp_parity = bus.in_exp_parity;
`endif

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = (state == S_HOLD);
    assign bus.out_parity = par_q;
    assign bus.out_count  = count_q;
    assign bus.out_err    = err_q;
endmodule

// File: tb/tb_xor_parity_frame_accum.sv
// Directed testbench for xor_parity_frame_accum (WIDTH=4, FRAME_LEN=4).
// dut_a uses ODD=0, dut_b uses ODD=1; both share clk and rst_n.
module tb_xor_parity_frame_accum;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

`ifdef PARITY_CHECK_EN
    localparam int CHK_EN = 1;
`else
    localparam int CHK_EN = 0;
`endif

    xor_parity_frame_accum_if #(.WIDTH(4), .FRAME_LEN(4)) ia ();
    xor_parity_frame_accum_if #(.WIDTH(4), .FRAME_LEN(4)) ib ();

    xor_parity_frame_accum #(.WIDTH(4), .FRAME_LEN(4), .ODD(0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia.slave)
    );

    xor_parity_frame_accum #(.WIDTH(4), .FRAME_LEN(4), .ODD(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [3:0] d, input logic last, input logic exp);
        ia.in_valid      = 1'b1;
        ia.in_data       = d;
        ia.in_last       = last;
        ia.in_exp_parity = exp;
        step();
        ia.in_valid = 1'b0;
        ia.in_last  = 1'b0;
    endtask

    task automatic send_b(input logic [3:0] d, input logic last);
        ib.in_valid = 1'b1;
        ib.in_data  = d;
        ib.in_last  = last;
        step();
        ib.in_valid = 1'b0;
        ib.in_last  = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        ia.in_valid = 1'b0; ia.in_data = '0; ia.in_last = 1'b0; ia.in_exp_parity = 1'b0; ia.out_ready = 1'b1;
        ib.in_valid = 1'b0; ib.in_data = '0; ib.in_last = 1'b0; ib.in_exp_parity = 1'b0; ib.out_ready = 1'b1;

        // reset state
        #2;
        chk("rst_in_ready",  int'(ia.in_ready),   0);
        chk("rst_out_valid", int'(ia.out_valid),  0);
        chk("rst_parity",    int'(ia.out_parity), 0);
        chk("rst_count",     int'(ia.out_count),  0);
        chk("rst_err",       int'(ia.out_err),    0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready_clocked", int'(ia.in_ready), 0);
        #4;
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", int'(ia.in_ready), 1);

        // in_last without in_valid has no effect
        ia.in_last = 1'b1;
        step();
        ia.in_last = 1'b0;
        chk("last_no_valid_out_valid", int'(ia.out_valid), 0);

        // full frame 1,3,7,F auto-closes; exp parity 1 mismatches parity 0
        send_a(4'h1, 1'b0, 1'b1);
        send_a(4'h3, 1'b0, 1'b1);
        send_a(4'h7, 1'b0, 1'b1);
        chk("full_no_early_close", int'(ia.out_valid), 0);
        send_a(4'hF, 1'b0, 1'b1);
        chk("full_out_valid", int'(ia.out_valid),  1);
        chk("full_parity",    int'(ia.out_parity), 0);
        chk("full_count",     int'(ia.out_count),  4);
        chk("full_err_exp1",  int'(ia.out_err),    CHK_EN);
        step();
        chk("full_one_valid_cycle", int'(ia.out_valid), 0);
        chk("full_in_ready_back",   int'(ia.in_ready),  1);

        // repeat with matching expected parity
        send_a(4'h1, 1'b0, 1'b0);
        send_a(4'h3, 1'b0, 1'b0);
        send_a(4'h7, 1'b0, 1'b0);
        send_a(4'hF, 1'b0, 1'b0);
        chk("full2_out_valid", int'(ia.out_valid), 1);
        chk("full2_err_exp0",  int'(ia.out_err),   0);
        step();

        // early last: 1,6 -> parity 1, count 2, one cycle of in_ready=0
        send_a(4'h1, 1'b0, 1'b0);
        send_a(4'h6, 1'b1, 1'b0);
        chk("early_out_valid", int'(ia.out_valid),  1);
        chk("early_parity",    int'(ia.out_parity), 1);
        chk("early_count",     int'(ia.out_count),  2);
        chk("early_in_ready0", int'(ia.in_ready),   0);
        step();
        chk("early_in_ready1", int'(ia.in_ready),   1);
        chk("early_valid_drop", int'(ia.out_valid), 0);

        // backpressure: result held, offered words ignored
        ia.out_ready = 1'b0;
        send_a(4'h1, 1'b0, 1'b0);
        send_a(4'h6, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            ia.in_valid = 1'b1;
            ia.in_data  = 4'hF;
            ia.in_last  = 1'b1;
            step();
            chk("bp_out_valid", int'(ia.out_valid),  1);
            chk("bp_parity",    int'(ia.out_parity), 1);
            chk("bp_count",     int'(ia.out_count),  2);
            chk("bp_in_ready",  int'(ia.in_ready),   0);
        end
        ia.in_valid  = 1'b0;
        ia.in_last   = 1'b0;
        ia.out_ready = 1'b1;
        step();
        chk("bp_release_valid", int'(ia.out_valid), 0);
        send_a(4'h3, 1'b1, 1'b0);
        chk("bp_next_parity", int'(ia.out_parity), 0);
        chk("bp_next_count",  int'(ia.out_count),  1);
        step();

        // ODD=1 instance: 8 alone -> 0; 0 alone -> 1
        send_b(4'h8, 1'b1);
        chk("odd_w8_valid",  int'(ib.out_valid),  1);
        chk("odd_w8_parity", int'(ib.out_parity), 0);
        chk("odd_w8_count",  int'(ib.out_count),  1);
        step();
        send_b(4'h0, 1'b1);
        chk("odd_w0_parity", int'(ib.out_parity), 1);
        chk("odd_w0_count",  int'(ib.out_count),  1);
        step();

        // reset mid-frame discards partial frame 1,3
        send_a(4'h1, 1'b0, 1'b0);
        send_a(4'h3, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", int'(ia.out_valid),  0);
        chk("mrst_parity",    int'(ia.out_parity), 0);
        chk("mrst_count",     int'(ia.out_count),  0);
        chk("mrst_in_ready",  int'(ia.in_ready),   0);
        #1;
        rst_n = 1'b1;
        step();
        chk("mrst_no_valid", int'(ia.out_valid), 0);
        send_a(4'h7, 1'b1, 1'b0);
        chk("mrst_next_valid",  int'(ia.out_valid),  1);
        chk("mrst_next_parity", int'(ia.out_parity), 1);
        chk("mrst_next_count",  int'(ia.out_count),  1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
